lsu_mem_stage: RTL

Load/store unit for the MEM stage of the pipelined RISC-V datapath. Takes the access decoded by the EX/MEM register and runs it against a data memory with a req/ack handshake. It stalls the pipeline until the access completes, then presents aligned, sign/zero-extended load data to the MEM/WB register as `read_data`. Byte, halfword and word accesses are supported, with a bus timeout.

---
 rtl/lsu_mem_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit for a pipelined RISC-V datapath.
// Runs one memory access per EX/MEM request over a req/ack data-memory bus.
// The pipeline is stalled until the access completes or times out. Load data
// is returned aligned and sign/zero-extended.
//
// Parameters:
//   TIMEOUT     max REQ cycles waited for dmem_ack before bus_error (1..255)
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   mem_read/mem_write  access request from EX/MEM (write wins)
//   funct3              000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   alu_result          byte address
//   write_data          store data (rs2)
//   dmem_rdata/dmem_ack memory read word and 1-cycle completion pulse
//   stall               combinational pipeline freeze
//   read_data           registered load result to MEM/WB
//   dmem_req/we/addr/wdata/be  registered memory request
//   bus_error           1-cycle pulse on timeout
//   misalign            1-cycle pulse on a trapped misaligned access
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined: misaligned H/W accesses are trapped (no
//                         request, misalign pulse). Undefined: the address is
//                         forced aligned and misalign is tied low.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic [31:0] read_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        bus_error,
   output logic        misalign
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_cnt;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic        w_access, w_start, w_is_b, w_is_h, w_timeout;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_access  = mem_read | mem_write;
   assign w_is_b    = (funct3 == 3'b000) || (funct3 == 3'b100);
   assign w_is_h    = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_mis, r_hold, r_misalign;
   assign w_mis    = (w_is_h & alu_result[0]) |
                     (~w_is_b & ~w_is_h & (alu_result[1:0] != 2'b00));
   // After a trap the same access stays on the inputs until the pipeline
   // flushes it; r_hold blocks it from re-trapping or being issued.
   assign w_start  = (r_state == S_IDLE) & w_access & ~w_mis & ~r_hold;
   assign misalign = r_misalign;
`else
   assign w_start  = (r_state == S_IDLE) & w_access;
   assign misalign = 1'b0;
`endif

   // Lane offset: half accesses drop bit 0 and words drop both bits, which is
   // the forced alignment in the default build and a no-op when trapping.
   always_comb begin
      w_off   = 2'b00;
      w_be    = 4'b1111;
      w_wdata = write_data;
      if (w_is_b) begin
         w_off   = alu_result[1:0];
         w_be    = 4'b0001 << alu_result[1:0];
         w_wdata = {4{write_data[7:0]}};
      end else if (w_is_h) begin
         w_off   = {alu_result[1], 1'b0};
         w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{write_data[15:0]}};
      end
   end

   always_comb begin
      w_byte = dmem_rdata[7:0];
      case (r_off)
         2'd1:    w_byte = dmem_rdata[15:8];
         2'd2:    w_byte = dmem_rdata[23:16];
         2'd3:    w_byte = dmem_rdata[31:24];
         default: w_byte = dmem_rdata[7:0];
      endcase
      w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (r_f3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = dmem_rdata;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      stall  = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall = w_start;
            if (w_start) w_next = S_REQ;
         end
         S_REQ: begin
            stall = 1'b1;
            if (dmem_ack || w_timeout) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt      <= '0;
         r_f3       <= '0;
         r_off      <= '0;
         read_data  <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         bus_error  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_hold     <= 1'b0;
         r_misalign <= 1'b0;
`endif
      end else begin
         bus_error <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
         if (r_state == S_IDLE) begin
            r_misalign <= w_access & w_mis & ~r_hold;
            r_hold     <= w_access & (r_hold | w_mis);
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {alu_result[31:2], 2'b00};
                  dmem_wdata <= w_wdata;
                  dmem_be    <= w_be;
                  r_f3       <= funct3;
                  r_off      <= w_off;
                  r_cnt      <= '0;
               end
            end
            S_REQ: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) read_data <= w_load;
               end else if (w_timeout) begin
                  dmem_req  <= 1'b0;
                  bus_error <= 1'b1;
                  if (!dmem_we) read_data <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
